// File: rtl/demux_1_2_reg_pkg.sv
// Shared constants for the registered 1:2 stream demultiplexer.
package demux_pkg;

   // Route-select encoding, same polarity as the 2:1 mux select.
   localparam logic SEL_A = 1'b1;
   localparam logic SEL_B = 1'b0;

   // Default widths.
   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/demux_1_2_reg_out_slot.sv
// One-entry valid/ready output register with load, drain and hold behaviour.
// o_free tells the producer side that a load this cycle will be absorbed,
// either because the slot is empty or because it is draining right now.
module out_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_free
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Load wins over drain so a simultaneous drain and refill keeps valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux_1_2_reg.sv
// Registered 1:2 stream demultiplexer. Each input beat goes to output A or B
// (from in_sel, or alternating when rr_en is set) and is buffered in a
// one-entry slot per output. Delivered beats are counted per output with
// saturating counters.
module demux_1_2_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             rr_en,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   logic             r_rr_ptr;
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;

   logic w_tgt;
   logic w_a_free;
   logic w_b_free;
   logic w_acc;
   logic w_load_a;
   logic w_load_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Effective route, acceptance and per-slot load strobes.
   always_comb begin
      w_tgt    = rr_en ? r_rr_ptr : in_sel;
      in_ready = !rst && ((w_tgt == SEL_A) ? w_a_free : w_b_free);
      w_acc    = in_valid && in_ready;
      w_load_a = w_acc && (w_tgt == SEL_A);
      w_load_b = w_acc && (w_tgt == SEL_B);
   end

   out_slot #(.WIDTH(WIDTH)) u_slot_a (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load_a),
      .i_data  (in_data),
      .i_ready (a_ready),
      .o_valid (a_valid),
      .o_data  (a_data),
      .o_free  (w_a_free)
   );

   out_slot #(.WIDTH(WIDTH)) u_slot_b (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load_b),
      .i_data  (in_data),
      .i_ready (b_ready),
      .o_valid (b_valid),
      .o_data  (b_data),
      .o_free  (w_b_free)
   );

   // Round-robin pointer: starts on A, toggles only on beats accepted in rr mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= SEL_A;
      end else if (w_acc && rr_en) begin
         r_rr_ptr <= !r_rr_ptr;
      end
   end

   // Delivered-beat counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt_a <= '0;
         r_cnt_b <= '0;
      end else begin
         if (a_valid && a_ready) r_cnt_a <= sat_inc(r_cnt_a);
         if (b_valid && b_ready) r_cnt_b <= sat_inc(r_cnt_b);
      end
   end

   assign cnt_a = r_cnt_a;
   assign cnt_b = r_cnt_b;

endmodule

// File: tb/tb_demux_1_2_reg.sv
// Directed bench for demux_1_2_reg (built with CNT_W=4 to reach saturation).
module tb_demux_1_2_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             rr_en;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   int n_vec;
   int n_err;

   demux_1_2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .rr_en    (rr_en),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .cnt_a    (cnt_a),
      .cnt_b    (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_sel   = 1'b1;
      rr_en    = 1'b0;
      a_ready  = 1'b1;
      b_ready  = 1'b1;

      // Reset held two cycles with a beat offered.
      step();
      step();
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_a_valid",  32'(a_valid),  32'd0);
      check_eq("rst_b_valid",  32'(b_valid),  32'd0);
      check_eq("rst_a_data",   32'(a_data),   32'd0);
      check_eq("rst_cnt_a",    32'(cnt_a),    32'd0);
      check_eq("rst_cnt_b",    32'(cnt_b),    32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      settle();
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed routing: 0x11 -> A, then 0x22 -> B.
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h11;
      settle();
      check_eq("route_rdy_a", 32'(in_ready), 32'd1);
      step();
      check_eq("route_a_valid", 32'(a_valid), 32'd1);
      check_eq("route_a_data",  32'(a_data),  32'h11);
      in_sel = 1'b0; in_data = 8'h22;
      settle();
      check_eq("route_rdy_b", 32'(in_ready), 32'd1);
      step();
      check_eq("route_b_valid", 32'(b_valid), 32'd1);
      check_eq("route_b_data",  32'(b_data),  32'h22);
      check_eq("route_a_drained", 32'(a_valid), 32'd0);
      check_eq("route_cnt_a", 32'(cnt_a), 32'd1);
      in_valid = 1'b0;
      step();
      check_eq("route_b_drained", 32'(b_valid), 32'd0);
      check_eq("route_cnt_b", 32'(cnt_b), 32'd1);

      // Backpressure isolation on A.
      a_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h33;
      step();
      check_eq("bp_a_data_33", 32'(a_data), 32'h33);
      in_data = 8'h44;
      settle();
      check_eq("bp_stall_rdy", 32'(in_ready), 32'd0);
      step();
      check_eq("bp_hold_valid", 32'(a_valid), 32'd1);
      check_eq("bp_hold_data",  32'(a_data),  32'h33);
      in_sel = 1'b0; in_data = 8'h55;
      settle();
      check_eq("bp_b_rdy", 32'(in_ready), 32'd1);
      step();
      check_eq("bp_b_data", 32'(b_data), 32'h55);
      check_eq("bp_a_still_33", 32'(a_data), 32'h33);
      in_valid = 1'b0;
      step();
      check_eq("bp_b_drained", 32'(b_valid), 32'd0);
      a_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h44;
      settle();
      check_eq("bp_refill_rdy", 32'(in_ready), 32'd1);
      check_eq("bp_deliver_33", 32'(a_data), 32'h33);
      step();
      check_eq("bp_deliver_44", 32'(a_data), 32'h44);
      in_valid = 1'b0;
      step();
      check_eq("bp_a_drained", 32'(a_valid), 32'd0);
      check_eq("bp_cnt_a", 32'(cnt_a), 32'd3);
      check_eq("bp_cnt_b", 32'(cnt_b), 32'd2);

      // Round-robin: A0..A5 alternate starting at A, no stalls.
      rr_en = 1'b1;
      in_sel = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(i);
         settle();
         check_eq("rr_rdy", 32'(in_ready), 32'd1);
         step();
         if (i % 2 == 0) begin
            check_eq("rr_a_valid", 32'(a_valid), 32'd1);
            check_eq("rr_a_data",  32'(a_data),  32'hA0 + 32'(i));
         end else begin
            check_eq("rr_b_valid", 32'(b_valid), 32'd1);
            check_eq("rr_b_data",  32'(b_data),  32'hA0 + 32'(i));
         end
      end
      in_valid = 1'b0;
      rr_en = 1'b0;
      step();
      check_eq("rr_cnt_a", 32'(cnt_a), 32'd6);
      check_eq("rr_cnt_b", 32'(cnt_b), 32'd5);

      // Clear counters, then full throughput to A.
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("clr_cnt_a", 32'(cnt_a), 32'd0);
      in_sel = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h10 + 8'(i);
         settle();
         check_eq("tput_rdy", 32'(in_ready), 32'd1);
         step();
         check_eq("tput_a_data", 32'(a_data), 32'h10 + 32'(i));
      end
      in_valid = 1'b0;
      step();
      check_eq("tput_cnt_a", 32'(cnt_a), 32'd10);

      // Saturation: 7 more beats (17 total) must pin cnt_a at 15.
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h60 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      check_eq("sat_cnt_a", 32'(cnt_a), 32'd15);

      // Mid-operation reset drops a stalled beat.
      a_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h77;
      step();
      in_valid = 1'b0;
      check_eq("mid_a_valid_pre", 32'(a_valid), 32'd1);
      rst = 1'b1;
      in_valid = 1'b1;
      settle();
      check_eq("mid_rst_rdy", 32'(in_ready), 32'd0);
      step();
      check_eq("mid_a_valid", 32'(a_valid), 32'd0);
      check_eq("mid_cnt_a", 32'(cnt_a), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
